// File: rtl/lif_chain.sv
// Chain of leaky integrate-and-fire neurons: neuron 0 takes the external current,
// each later neuron takes WEIGHT when its predecessor spiked on the previous edge.

module lif_neuron #(
    parameter int WIDTH          = 8,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRACT_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic             spike_o,
    output logic [WIDTH-1:0] state_o
);
    localparam int RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
    localparam logic [RW-1:0]  REFR_INIT = RW'(REFRACT_CYCLES);
    localparam logic [WIDTH:0] THR       = (WIDTH + 1)'(THRESHOLD);

    logic [WIDTH-1:0] state_q, state_d;
    logic [RW-1:0]    refr_q, refr_d;
    logic             spike_q, spike_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;

    // One extra bit catches overflow so the sum clamps instead of wrapping.
    always_comb begin
        sum = {1'b0, state_q >> LEAK_SHIFT} + {1'b0, cur_i};
        sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        refr_d  = refr_q;
        spike_d = 1'b0;
        if (en_i) begin
            if (refr_q != '0) begin
                state_d = '0;
                refr_d  = refr_q - 1'b1;
            end else if ({1'b0, sat} >= THR) begin
                spike_d = 1'b1;
                state_d = '0;
                refr_d  = REFR_INIT;
            end else begin
                state_d = sat;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
    assign state_o = state_q;
endmodule

module lif_chain #(
    parameter int NUM_NEURONS    = 3,
    parameter int WIDTH          = 8,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRACT_CYCLES = 2,
    parameter int WEIGHT         = 255,
    parameter int CNT_WIDTH      = 16,
    parameter int SEL_W          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [WIDTH-1:0]       current_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic                   cnt_clr_i,
    output logic [NUM_NEURONS-1:0] spikes_o,
    output logic [WIDTH-1:0]       state_out_o,
    output logic [CNT_WIDTH-1:0]   spike_cnt_o
);
    localparam logic [WIDTH-1:0] WGT = WIDTH'(WEIGHT);

    logic [NUM_NEURONS-1:0][WIDTH-1:0] cur, st;
    logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_lane
            if (g == 0) begin : g_head
                assign cur[g] = current_i;
            end else begin : g_link
                assign cur[g] = spikes_o[g-1] ? WGT : '0;
            end
            lif_neuron #(
                .WIDTH          (WIDTH),
                .THRESHOLD      (THRESHOLD),
                .LEAK_SHIFT     (LEAK_SHIFT),
                .REFRACT_CYCLES (REFRACT_CYCLES)
            ) u_neuron (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .en_i    (en_i),
                .cur_i   (cur[g]),
                .spike_o (spikes_o[g]),
                .state_o (st[g])
            );
        end
    endgenerate

    // Unmatched select codes fall through to zero.
    always_comb begin
        state_out_o = '0;
        for (int i = 0; i < NUM_NEURONS; i++)
            if (sel_i == SEL_W'(i)) state_out_o = st[i];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i)
            cnt_d = '0;
        else if (en_i && spikes_o[NUM_NEURONS-1] && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign spike_cnt_o = cnt_q;
endmodule

// File: tb/tb_lif_chain.sv
// Bench for lif_chain: default instance plus a THRESHOLD=255 / CNT_WIDTH=2 instance,
// both checked every cycle against an integer model, with directed literal checks.

module tb_lif_chain;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] current = '0;
    logic [1:0] sel = '0;
    logic       cnt_clr = 1'b0;

    logic [2:0]  spikes1, spikes2;
    logic [7:0]  so1, so2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int tests = 0;
    int fails = 0;

    int m_st  [2][3];
    int m_rf  [2][3];
    int m_sp  [2][3];
    int m_cnt [2];

    always #5 clk = ~clk;

    lif_chain dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .current_i(current), .sel_i(sel),
        .cnt_clr_i(cnt_clr), .spikes_o(spikes1), .state_out_o(so1), .spike_cnt_o(cnt1)
    );

    lif_chain #(.THRESHOLD(255), .CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .current_i(current), .sel_i(sel),
        .cnt_clr_i(cnt_clr), .spikes_o(spikes2), .state_out_o(so2), .spike_cnt_o(cnt2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Integer reference: one clock edge for instance k.
    task automatic model_edge(input int k);
        int thr, cmax, inp, sum;
        int osp [3];
        thr  = (k == 1) ? 255 : 200;
        cmax = (k == 1) ? 3 : 65535;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_st[k][i] = 0; m_rf[k][i] = 0; m_sp[k][i] = 0;
            end
            m_cnt[k] = 0;
            return;
        end
        if (cnt_clr) m_cnt[k] = 0;
        else if (en && m_sp[k][2] != 0) m_cnt[k] = (m_cnt[k] >= cmax) ? cmax : m_cnt[k] + 1;
        for (int i = 0; i < 3; i++) osp[i] = m_sp[k][i];
        for (int i = 0; i < 3; i++) begin
            if (!en) begin
                m_sp[k][i] = 0;
            end else begin
                inp = (i == 0) ? int'(current) : ((osp[i-1] != 0) ? 255 : 0);
                if (m_rf[k][i] > 0) begin
                    m_st[k][i] = 0; m_rf[k][i]--; m_sp[k][i] = 0;
                end else begin
                    sum = m_st[k][i] / 2 + inp;
                    if (sum > 255) sum = 255;
                    if (sum >= thr) begin
                        m_sp[k][i] = 1; m_st[k][i] = 0; m_rf[k][i] = 2;
                    end else begin
                        m_sp[k][i] = 0; m_st[k][i] = sum;
                    end
                end
            end
        end
    endtask

    function automatic int exp_spk(input int k);
        return m_sp[k][0] + 2 * m_sp[k][1] + 4 * m_sp[k][2];
    endfunction

    function automatic int exp_so(input int k);
        return (int'(sel) < 3) ? m_st[k][sel] : 0;
    endfunction

    task automatic compare_all();
        chk("spikes1", int'(spikes1), exp_spk(0));
        chk("state1",  int'(so1),     exp_so(0));
        chk("cnt1",    int'(cnt1),    m_cnt[0]);
        chk("spikes2", int'(spikes2), exp_spk(1));
        chk("state2",  int'(so2),     exp_so(1));
        chk("cnt2",    int'(cnt2),    m_cnt[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; current = '0; sel = '0;
        step();
        rst = 1'b0;
    endtask

    int conv [9] = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
    bit found;

    initial begin
        // reset held two edges, then idle
        rst = 1'b1;
        step(); step();
        chk("rst_spk", int'(spikes1), 0);
        chk("rst_st",  int'(so1), 0);
        chk("rst_cnt", int'(cnt1), 0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_st", int'(so1), 0);

        // current=120: neuron0 fires on edge 3, chain propagates
        en = 1'b1; current = 8'd120;
        step(); chk("e1_st", int'(so1), 120);
        step(); chk("e2_st", int'(so1), 180);
        step(); chk("e3_spk", int'(spikes1), 1); chk("e3_st", int'(so1), 0);
        step(); chk("e4_spk", int'(spikes1), 2); chk("e4_st", int'(so1), 0);
        step(); chk("e5_spk", int'(spikes1), 4); chk("e5_st", int'(so1), 0);
        step(); chk("e6_cnt", int'(cnt1), 1); chk("e6_st", int'(so1), 120);
        sel = 2'd3; #1; chk("sel_oob", int'(so1), 0);
        sel = 2'd0;

        // sub-threshold convergence
        do_reset();
        en = 1'b1; current = 8'd100;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i < 9) chk("conv_st", int'(so1), conv[i]);
            chk("conv_nospk", int'(spikes1[0]), 0);
        end

        // saturation at THRESHOLD=255 and 2-bit counter saturation
        do_reset();
        en = 1'b1; current = 8'd255;
        step(); chk("sat_fire", int'(spikes2[0]), 1);
        repeat (29) step();
        chk("cnt2_sat", int'(cnt2), 3);

        // en=0 holds mid-integration
        do_reset();
        en = 1'b1; current = 8'd120;
        step(); step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_st", int'(so1), 180);
        end
        en = 1'b1;
        step();

        // reset during refractory
        do_reset();
        en = 1'b1; current = 8'd255;
        step();
        rst = 1'b1;
        step();
        chk("rrf_spk", int'(spikes1), 0);
        chk("rrf_st",  int'(so1), 0);
        rst = 1'b0;

        // clear coinciding with an output spike
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (m_sp[0][2] != 0) found = 1'b1;
        end
        chk("wait_spk2", int'(found), 1);
        cnt_clr = 1'b1;
        step();
        chk("clr_cnt", int'(cnt1), 0);
        cnt_clr = 1'b0;

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 7) != 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            current = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(180, 255))
                                                   : 8'($urandom_range(0, 255));
            sel     = 2'($urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
